// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
// -----------------------------------------------------------------------------
// ID/EX hazard controller. It detects load-use hazards between the instruction
// in ID and a load in EX, and inserts BUBBLES bubbles for each one. It registers
// the decoded control bundle into the EX stage and zeroes it for a bubble or a
// flush. It freezes the whole front end while the data memory is busy, and it
// keeps a saturating count of inserted bubble cycles.
//
// Handshake / priority (one rule for the whole block):
//   rst_i > mem_busy_i > flush_i > BUBBLE state > hazard > normal pass-through.
//   mem_busy_i holds every register. pc_write_o and ifid_write_o are the
//   "ready" signals back to the front end: the ID instruction is consumed on
//   an edge only when both are 1.
//
// Ports
//   clk_i, rst_i      clock, synchronous active-high reset
//   ctrl_i, valid_i   decoded control bundle / valid of the ID instruction
//   rs_addr_i         NUM_SRC source addresses, slot k = [k*RA_W +: RA_W]
//   rs_use_i          slot k is really read
//   ex_memread_i      instruction in EX is a load
//   ex_rd_addr_i      destination register of the instruction in EX
//   mem_busy_i        data memory not ready: freeze
//   flush_i           kill the ID instruction and cancel pending bubbles
//   clr_cnt_i         clear the bubble counter
//   ctrl_o, valid_o   registered ID/EX control bundle and valid
//   pc_write_o        PC may update this cycle (comb)
//   ifid_write_o      IF/ID may update this cycle (comb)
//   bubble_o          a bubble is inserted this cycle (comb)
//   bubble_cnt_o      saturating bubble counter
// -----------------------------------------------------------------------------
module hazard_stall_ctrl #(
  parameter int CTRL_W  = 8,
  parameter int NUM_SRC = 2,
  parameter int RA_W    = 5,
  parameter int BUBBLES = 1,
  parameter int CNT_W   = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [CTRL_W-1:0]       ctrl_i,
  input  logic                    valid_i,
  input  logic [NUM_SRC*RA_W-1:0] rs_addr_i,
  input  logic [NUM_SRC-1:0]      rs_use_i,
  input  logic                    ex_memread_i,
  input  logic [RA_W-1:0]         ex_rd_addr_i,
  input  logic                    mem_busy_i,
  input  logic                    flush_i,
  input  logic                    clr_cnt_i,
  output logic [CTRL_W-1:0]       ctrl_o,
  output logic                    valid_o,
  output logic                    pc_write_o,
  output logic                    ifid_write_o,
  output logic                    bubble_o,
  output logic [CNT_W-1:0]        bubble_cnt_o
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_BUBBLE = 1'b1
  } state_t;

  // Bubbles still owed after the first one, which is taken in RUN.
  localparam logic [3:0]       REMAIN_INIT = 4'(BUBBLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  state_t            state_q;
  logic [3:0]        remain_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic              valid_q;
  logic [CNT_W-1:0]  cnt_q;

  logic src_match;
  logic hazard;
  logic in_bubble;
  logic bubble;

  // Compare every used source slot against the destination of the load in EX.
  always_comb begin
    src_match = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (rs_use_i[k] && (rs_addr_i[k*RA_W +: RA_W] == ex_rd_addr_i)) begin
        src_match = 1'b1;
      end
    end
  end

  // x0 is hard-wired to zero, so a load to it never creates a dependency.
  assign hazard    = valid_i && ex_memread_i && (ex_rd_addr_i != '0) && src_match;
  assign in_bubble = (state_q == ST_BUBBLE);

  // Freeze and flush both override bubbles. The BUBBLE state ignores hazard.
  assign bubble       = !mem_busy_i && !flush_i && (in_bubble || hazard);
  assign bubble_o     = bubble;
  assign pc_write_o   = !mem_busy_i && !bubble;
  assign ifid_write_o = !mem_busy_i && !bubble;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_RUN;
      remain_q <= '0;
      ctrl_q   <= '0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
    end else if (!mem_busy_i) begin
      if (flush_i) begin
        state_q  <= ST_RUN;
        remain_q <= '0;
        ctrl_q   <= '0;
        valid_q  <= 1'b0;
      end else if (in_bubble) begin
        ctrl_q   <= '0;
        valid_q  <= 1'b0;
        remain_q <= remain_q - 4'd1;
        if (remain_q == 4'd1) begin
          state_q <= ST_RUN;
        end
      end else if (hazard) begin
        ctrl_q  <= '0;
        valid_q <= 1'b0;
        if (BUBBLES > 1) begin
          state_q  <= ST_BUBBLE;
          remain_q <= REMAIN_INIT;
        end
      end else begin
        ctrl_q  <= ctrl_i;
        valid_q <= valid_i;
      end

      if (clr_cnt_i) begin
        cnt_q <= '0;
      end else if (bubble && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign ctrl_o       = ctrl_q;
  assign valid_o      = valid_q;
  assign bubble_cnt_o = cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Testbench for hazard_stall_ctrl. Two instances share the input stimulus:
// u_b1 (BUBBLES=1, CNT_W=4) and u_b3 (BUBBLES=3, CNT_W=16). Each directed
// step checks only the instance it targets.
module tb_hazard_stall_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  ctrl_in;
  logic        valid_in;
  logic [9:0]  rs_addr;
  logic [1:0]  rs_use;
  logic        ex_memread;
  logic [4:0]  ex_rd;
  logic        mem_busy;
  logic        flush;
  logic        clr_cnt;

  logic [7:0]  o1_ctrl, o3_ctrl;
  logic        o1_valid, o3_valid;
  logic        o1_pcw, o3_pcw;
  logic        o1_ifw, o3_ifw;
  logic        o1_bub, o3_bub;
  logic [3:0]  o1_cnt;
  logic [15:0] o3_cnt;

  int n_checks = 0;
  int n_errors = 0;

  hazard_stall_ctrl #(.CTRL_W(8), .NUM_SRC(2), .RA_W(5), .BUBBLES(1), .CNT_W(4)) u_b1 (
    .clk_i(clk), .rst_i(rst), .ctrl_i(ctrl_in), .valid_i(valid_in),
    .rs_addr_i(rs_addr), .rs_use_i(rs_use), .ex_memread_i(ex_memread),
    .ex_rd_addr_i(ex_rd), .mem_busy_i(mem_busy), .flush_i(flush),
    .clr_cnt_i(clr_cnt), .ctrl_o(o1_ctrl), .valid_o(o1_valid),
    .pc_write_o(o1_pcw), .ifid_write_o(o1_ifw), .bubble_o(o1_bub),
    .bubble_cnt_o(o1_cnt)
  );

  hazard_stall_ctrl #(.CTRL_W(8), .NUM_SRC(2), .RA_W(5), .BUBBLES(3), .CNT_W(16)) u_b3 (
    .clk_i(clk), .rst_i(rst), .ctrl_i(ctrl_in), .valid_i(valid_in),
    .rs_addr_i(rs_addr), .rs_use_i(rs_use), .ex_memread_i(ex_memread),
    .ex_rd_addr_i(ex_rd), .mem_busy_i(mem_busy), .flush_i(flush),
    .clr_cnt_i(clr_cnt), .ctrl_o(o3_ctrl), .valid_o(o3_valid),
    .pc_write_o(o3_pcw), .ifid_write_o(o3_ifw), .bubble_o(o3_bub),
    .bubble_cnt_o(o3_cnt)
  );

  // ---------------- driver tasks ----------------
  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  task automatic set_hazard(input logic [4:0] rd, input logic [4:0] s1,
                            input logic [4:0] s0, input logic [1:0] use_v);
    ex_memread = 1'b1;
    ex_rd      = rd;
    rs_addr    = {s1, s0};
    rs_use     = use_v;
  endtask

  task automatic no_hazard();
    ex_memread = 1'b0;
    ex_rd      = 5'd0;
    rs_addr    = '0;
    rs_use     = 2'b00;
  endtask

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; ctrl_in = 8'hFF; valid_in = 1'b1;
    mem_busy = 1'b0; flush = 1'b0; clr_cnt = 1'b0;
    no_hazard();

    // T1 reset held for 2 cycles with a live bundle on the input
    tick(); tick();
    check("t1_ctrl",  32'(o1_ctrl),  32'h0);
    check("t1_valid", 32'(o1_valid), 32'h0);
    check("t1_cnt",   32'(o1_cnt),   32'h0);
    check("t1_pcw",   32'(o1_pcw),   32'h1);
    check("t1_ifw",   32'(o1_ifw),   32'h1);
    check("t1_bub",   32'(o1_bub),   32'h0);
    check("t1_ctrl3", 32'(o3_ctrl),  32'h0);
    rst = 1'b0;

    // T2 pass-through with 1-cycle latency
    ctrl_in = 8'hA5; valid_in = 1'b1;
    settle();
    check("t2_pcw_pre", 32'(o1_pcw), 32'h1);
    check("t2_bub_pre", 32'(o1_bub), 32'h0);
    tick();
    check("t2_ctrl",  32'(o1_ctrl),  32'hA5);
    check("t2_valid", 32'(o1_valid), 32'h1);
    check("t2_ctrl3", 32'(o3_ctrl),  32'hA5);
    check("t2_pcw",   32'(o1_pcw),   32'h1);

    // T3 load-use with BUBBLES=1: slot1 reads r5, the load in EX writes r5
    ctrl_in = 8'h3C;
    set_hazard(5'd5, 5'd5, 5'd2, 2'b10);
    settle();
    check("t3_bub",  32'(o1_bub), 32'h1);
    check("t3_pcw",  32'(o1_pcw), 32'h0);
    check("t3_ifw",  32'(o1_ifw), 32'h0);
    tick();
    check("t3_ctrl_bubble",  32'(o1_ctrl),  32'h0);
    check("t3_valid_bubble", 32'(o1_valid), 32'h0);
    no_hazard();  // the bubble is now in EX
    settle();
    check("t3_pcw_resume", 32'(o1_pcw), 32'h1);
    check("t3_bub_resume", 32'(o1_bub), 32'h0);
    tick();
    check("t3_ctrl_fwd", 32'(o1_ctrl), 32'h3C);
    check("t3_cnt",      32'(o1_cnt),  32'h1);

    // T4 BUBBLES=3: start from reset
    rst = 1'b1; tick(); rst = 1'b0;
    ctrl_in = 8'h5A; valid_in = 1'b1;
    set_hazard(5'd7, 5'd1, 5'd7, 2'b01);
    settle();
    check("t4_bub_c0", 32'(o3_bub), 32'h1);
    check("t4_pcw_c0", 32'(o3_pcw), 32'h0);
    tick();
    check("t4_ctrl_c0", 32'(o3_ctrl), 32'h0);
    settle();  // hazard still present but ignored in BUBBLE state
    check("t4_bub_c1", 32'(o3_bub), 32'h1);
    check("t4_pcw_c1", 32'(o3_pcw), 32'h0);
    tick();
    check("t4_ctrl_c1", 32'(o3_ctrl), 32'h0);
    no_hazard();
    settle();
    check("t4_bub_c2", 32'(o3_bub), 32'h1);
    check("t4_ifw_c2", 32'(o3_ifw), 32'h0);
    tick();
    check("t4_ctrl_c2",  32'(o3_ctrl),  32'h0);
    check("t4_valid_c2", 32'(o3_valid), 32'h0);
    settle();
    check("t4_pcw_c3", 32'(o3_pcw), 32'h1);
    check("t4_bub_c3", 32'(o3_bub), 32'h0);
    tick();
    check("t4_ctrl_fwd", 32'(o3_ctrl),  32'h5A);
    check("t4_valid_fwd", 32'(o3_valid), 32'h1);
    check("t4_cnt",      32'(o3_cnt),   32'h3);

    // T4 negatives: load to x0, then an unused slot
    ctrl_in = 8'h66;
    set_hazard(5'd0, 5'd1, 5'd0, 2'b01);
    settle();
    check("t4_x0_bub", 32'(o3_bub), 32'h0);
    check("t4_x0_pcw", 32'(o3_pcw), 32'h1);
    tick();
    check("t4_x0_ctrl", 32'(o3_ctrl), 32'h66);
    ctrl_in = 8'h77;
    set_hazard(5'd7, 5'd1, 5'd7, 2'b00);
    settle();
    check("t4_unused_bub", 32'(o3_bub), 32'h0);
    tick();
    check("t4_unused_ctrl", 32'(o3_ctrl), 32'h77);
    check("t4_neg_cnt",     32'(o3_cnt),  32'h3);

    // T5 freeze mid-BUBBLE, then flush
    ctrl_in = 8'h11;
    set_hazard(5'd9, 5'd9, 5'd3, 2'b10);
    tick();  // BUBBLES=3 instance enters BUBBLE with 2 remaining
    check("t5_ctrl_enter", 32'(o3_ctrl), 32'h0);
    check("t5_cnt_enter",  32'(o3_cnt),  32'h4);
    no_hazard();
    ctrl_in  = 8'h22;
    mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("t5_busy_pcw", 32'(o3_pcw), 32'h0);
      check("t5_busy_ifw", 32'(o3_ifw), 32'h0);
      check("t5_busy_bub", 32'(o3_bub), 32'h0);
      tick();
      check("t5_busy_ctrl",  32'(o3_ctrl),  32'h0);
      check("t5_busy_valid", 32'(o3_valid), 32'h0);
      check("t5_busy_cnt",   32'(o3_cnt),   32'h4);
    end
    mem_busy = 1'b0;
    settle();
    check("t5_unfreeze_bub", 32'(o3_bub), 32'h1);
    tick();
    check("t5_unfreeze_cnt", 32'(o3_cnt), 32'h5);
    flush = 1'b1;
    settle();
    check("t5_flush_bub", 32'(o3_bub), 32'h0);
    check("t5_flush_pcw", 32'(o3_pcw), 32'h1);
    tick();
    check("t5_flush_ctrl",  32'(o3_ctrl),  32'h0);
    check("t5_flush_valid", 32'(o3_valid), 32'h0);
    flush   = 1'b0;
    ctrl_in = 8'h33;
    settle();
    check("t5_after_bub", 32'(o3_bub), 32'h0);
    check("t5_after_pcw", 32'(o3_pcw), 32'h1);
    tick();
    check("t5_after_ctrl", 32'(o3_ctrl), 32'h33);
    check("t5_after_cnt",  32'(o3_cnt),  32'h5);

    // T6 counter saturation on the CNT_W=4 instance: 18 back-to-back bubbles
    rst = 1'b1; tick(); rst = 1'b0;
    ctrl_in = 8'h44;
    set_hazard(5'd4, 5'd4, 5'd4, 2'b11);
    for (int i = 0; i < 14; i++) tick();
    check("t6_cnt14", 32'(o1_cnt), 32'hE);
    for (int i = 0; i < 4; i++) tick();
    check("t6_cnt_sat", 32'(o1_cnt), 32'hF);
    clr_cnt = 1'b1;
    settle();
    check("t6_clr_bub", 32'(o1_bub), 32'h1);
    tick();
    check("t6_clr_cnt", 32'(o1_cnt), 32'h0);
    clr_cnt = 1'b0;
    tick();
    check("t6_inc_after_clr", 32'(o1_cnt), 32'h1);
    no_hazard();
    tick();
    check("t6_ctrl_fwd", 32'(o1_ctrl), 32'h44);

    // Reset while frozen in BUBBLE returns to reset values
    set_hazard(5'd4, 5'd4, 5'd4, 2'b01);
    tick();
    no_hazard();
    mem_busy = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_busy = 1'b0;
    settle();
    check("rst_freeze_bub", 32'(o3_bub), 32'h0);
    check("rst_freeze_pcw", 32'(o3_pcw), 32'h1);
    check("rst_freeze_cnt", 32'(o3_cnt), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
